// File: rtl/lvt_write_scheduler_if.sv
// ----------------------------------------------------------------------------
// lvt_write_scheduler_if
// Bundle between the write requesters and the LVT write scheduler, plus the
// scheduler's four registered RAM write ports.
//   req_valid  [NREQ]          requester i has a write pending
//   req_addr   [NREQ*ADDR_W]   requester i address, slice [i*ADDR_W +: ADDR_W]
//   req_data   [NREQ*DATA_W]   requester i data,    slice [i*DATA_W +: DATA_W]
//   req_ready  [NREQ]          requester i granted this cycle (combinational)
//   w_addr_k / w_din_k / w_enb_k (k=1..4)  registered RAM write port k
// Modports: master = requester / RAM side, slave = scheduler.
// ----------------------------------------------------------------------------
interface lvt_write_scheduler_if #(
    parameter int NREQ   = 6,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;

    logic [ADDR_W-1:0] w_addr_1, w_addr_2, w_addr_3, w_addr_4;
    logic [DATA_W-1:0] w_din_1,  w_din_2,  w_din_3,  w_din_4;
    logic              w_enb_1,  w_enb_2,  w_enb_3,  w_enb_4;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready,
        input  w_addr_1, w_addr_2, w_addr_3, w_addr_4,
        input  w_din_1,  w_din_2,  w_din_3,  w_din_4,
        input  w_enb_1,  w_enb_2,  w_enb_3,  w_enb_4
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready,
        output w_addr_1, w_addr_2, w_addr_3, w_addr_4,
        output w_din_1,  w_din_2,  w_din_3,  w_din_4,
        output w_enb_1,  w_enb_2,  w_enb_3,  w_enb_4
    );
endinterface

// File: rtl/lvt_write_scheduler.sv
// ----------------------------------------------------------------------------
// lvt_write_scheduler
// Grants up to four of NREQ write requesters per cycle in rotating priority,
// never granting two writes to the same address in one cycle, and drives the
// granted set onto the LVT RAM's four write ports from registers.
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   bus        lvt_write_scheduler_if.slave (requests, ready, write ports)
//   stall_cnt  16-bit saturating stall counter (only with LVT_WSCHED_STATS_EN)
// Optional feature macro: LVT_WSCHED_STATS_EN
// ----------------------------------------------------------------------------
module lvt_write_scheduler #(
    parameter int NREQ   = 6,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    lvt_write_scheduler_if.slave   bus
`ifdef LVT_WSCHED_STATS_EN
    ,
    output logic [15:0]            stall_cnt
`endif
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  idx;
    logic [PTR_W-1:0]  last_idx;
    logic [PTR_W-1:0]  next_ptr;
    logic [NREQ-1:0]   ready;
    logic [2:0]        gcnt;
    logic              conflict;
    logic [ADDR_W-1:0] cand_addr;
    logic [ADDR_W-1:0] g_addr [4];
    logic [DATA_W-1:0] g_data [4];
    logic [3:0]        g_vld;

    logic [ADDR_W-1:0] w_addr_q [4];
    logic [DATA_W-1:0] w_din_q  [4];
    logic [3:0]        w_enb_q;

    // Single pass over the NREQ candidates starting at ptr; the k-th grant
    // lands in slot k so port order follows scan order.
    always_comb begin
        ready     = '0;
        gcnt      = 3'd0;
        g_vld     = '0;
        last_idx  = ptr;
        idx       = ptr;
        conflict  = 1'b0;
        cand_addr = '0;
        for (int k = 0; k < 4; k++) begin
            g_addr[k] = '0;
            g_data[k] = '0;
        end
        if (!rst) begin
            for (int j = 0; j < NREQ; j++) begin
                cand_addr = bus.req_addr[int'(idx)*ADDR_W +: ADDR_W];
                conflict  = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (g_vld[k] && (g_addr[k] == cand_addr))
                        conflict = 1'b1;
                end
                if (bus.req_valid[idx] && (gcnt < 3'd4) && !conflict) begin
                    ready[idx]          = 1'b1;
                    g_vld[gcnt[1:0]]    = 1'b1;
                    g_addr[gcnt[1:0]]   = cand_addr;
                    g_data[gcnt[1:0]]   = bus.req_data[int'(idx)*DATA_W +: DATA_W];
                    last_idx            = idx;
                    gcnt                = gcnt + 3'd1;
                end
                idx = (idx == PTR_W'(NREQ-1)) ? '0 : idx + PTR_W'(1);
            end
        end
    end

    assign next_ptr      = (last_idx == PTR_W'(NREQ-1)) ? '0 : last_idx + PTR_W'(1);
    assign bus.req_ready = ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            w_enb_q <= '0;
            for (int k = 0; k < 4; k++) begin
                w_addr_q[k] <= '0;
                w_din_q[k]  <= '0;
            end
        end else begin
            w_enb_q <= g_vld;
            // Idle ports keep their last address/data.
            for (int k = 0; k < 4; k++) begin
                if (g_vld[k]) begin
                    w_addr_q[k] <= g_addr[k];
                    w_din_q[k]  <= g_data[k];
                end
            end
            if (gcnt != 3'd0)
                ptr <= next_ptr;
        end
    end

    assign bus.w_addr_1 = w_addr_q[0];
    assign bus.w_addr_2 = w_addr_q[1];
    assign bus.w_addr_3 = w_addr_q[2];
    assign bus.w_addr_4 = w_addr_q[3];
    assign bus.w_din_1  = w_din_q[0];
    assign bus.w_din_2  = w_din_q[1];
    assign bus.w_din_3  = w_din_q[2];
    assign bus.w_din_4  = w_din_q[3];
    assign bus.w_enb_1  = w_enb_q[0];
    assign bus.w_enb_2  = w_enb_q[1];
    assign bus.w_enb_3  = w_enb_q[2];
    assign bus.w_enb_4  = w_enb_q[3];

`ifdef LVT_WSCHED_STATS_EN
    logic        stall;
    logic [15:0] stall_q;

    // A stall is any valid requester left ungranted this cycle.
    assign stall = |(bus.req_valid & ~ready);

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (stall && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`endif
endmodule

// File: doc/lvt_write_scheduler.md
# lvt_write_scheduler

Write-port scheduler in front of the 8-read/4-write LVT RAM. Accepts up to NREQ independent write requesters using valid/ready handshakes and grants up to four per cycle. Grants follow a rotating (round-robin) priority, and no two grants in one cycle target the same address. Granted writes are driven onto the RAM's four write ports from registers, so the RAM sees one clean, conflict-free write set per cycle.

## Interface
Parameters:
- NREQ, 6, number of write requesters; legal range 4..8.
- ADDR_W, 11, write address width; equals RAM BLOCKSIZE+1.
- DATA_W, 32, write data width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  NREQ  bit i: requester i has a write pending.
- req_addr  input  NREQ*ADDR_W  requester i address in slice [i*ADDR_W +: ADDR_W].
- req_data  input  NREQ*DATA_W  requester i data in slice [i*DATA_W +: DATA_W].
- req_ready  output  NREQ  bit i: requester i is granted this cycle; combinational.
- w_addr_1..w_addr_4  output  ADDR_W each  registered RAM write addresses.
- w_din_1..w_din_4  output  DATA_W each  registered RAM write data.
- w_enb_1..w_enb_4  output  1 each  registered RAM write enables.
- stall_cnt  output  16  saturating stall counter; present only with LVT_WSCHED_STATS_EN.

## Operation
- Handshake: a transfer occurs on a rising edge when req_valid[i] and req_ready[i] are both 1.
- req_ready[i] depends only on the current req_valid, req_addr and internal state.
- req_ready[i] is 0 whenever req_valid[i] is 0 or rst is 1.
- Requesters hold addr and data stable while valid and not ready.
- Priority pointer ptr has width ceil(log2 NREQ) and resets to 0.
- Scan order per cycle: ptr, ptr+1, ..., wrapping modulo NREQ, NREQ candidates in total.
- Grant rule: a candidate is granted if all of the following hold:
  - it is valid;
  - fewer than 4 grants have already been made this cycle;
  - its address differs from every address already granted this cycle.
- Same-address losers keep req_ready=0 and retry next cycle.
- Port mapping: the k-th grant in scan order (k=1..4) drives w_addr_k, w_din_k and w_enb_k. Unused ports get w_enb_k=0.
- Pointer update: if at least one grant, ptr <= (index of last grant + 1) mod NREQ; otherwise ptr is unchanged.
- Starvation bound: a continuously valid requester is granted within NREQ cycles.
- A port with w_enb_k=0 holds its previous w_addr_k and w_din_k values.

## Timing
- Latency: a handshake on edge N gives w_enb_k=1 with matching addr/din for the full cycle after edge N, i.e. until edge N+1.
- The RAM's LVT and banks sample these registered ports mid-cycle (falling edge), so outputs are stable half a cycle before the sample.
- Throughput: up to 4 writes per cycle, with no bubbles between cycles.
- Reset: on an edge with rst=1, the following take effect at that edge:
  - all w_enb_k=0;
  - all w_addr_k=0 and w_din_k=0;
  - ptr=0;
  - stall_cnt=0.
- A handshake cannot coincide with reset, because req_ready is forced 0 while rst=1.
- Reset mid-operation drops nothing already granted. Ungranted requests stay the requesters' responsibility.
- NREQ ≤ 4 with distinct addresses: every valid requester is granted in the same cycle.

## Configuration
- Macro: LVT_WSCHED_STATS_EN.
- Defined: stall_cnt port and logic are present.
  - stall_cnt increments by 1 on each edge where at least one valid requester is not granted.
  - It saturates at 16'hFFFF and clears on rst.
- Undefined: stall_cnt port and counter are absent; scheduling behaviour is identical.

## Test plan
- Reset: hold rst=1 for 2 cycles with all req_valid=1 -> all req_ready=0; all w_enb_k=0, w_addr_k=0 and w_din_k=0; stall_cnt=0.
- Full load: NREQ=6, ptr=0, all valid, addresses 0x10..0x15 ->
  - cycle 1: grants 0..3, with w_addr_1..4 = 0x10..0x13 one cycle later; ptr becomes 4;
  - cycle 2: grants 4, 5, 0, 1 in scan order.
- Collision: requesters 0 and 2 both target 0x3A with data 0xAAAA0000 and 0xBBBB0000, ptr=0 ->
  - cycle 1: only requester 0 is granted, giving w_addr_1=0x3A, w_din_1=0xAAAA0000;
  - next cycle: requester 2 is granted and 0xBBBB0000 appears on a write port.
- Fairness: requester 5 held valid while requesters 0..4 are always valid with distinct addresses -> requester 5 is granted within 6 cycles, and every requester's grant count stays within 1 of the others over 60 cycles.
- Sparse: only requester 3 valid, addr 0x7FF, data 0xDEADBEEF -> next cycle w_enb_1=1, w_addr_1=0x7FF, w_din_1=0xDEADBEEF, and w_enb_2..4=0. Then ptr=4.
- Stats (LVT_WSCHED_STATS_EN): 6 valid distinct requesters for 10 cycles -> stall_cnt=10. After forcing the counter to 0xFFFE, 3 more stall cycles -> stall_cnt=0xFFFF.
